// File: rtl/block_reorder.sv
// rtl/block_reorder.sv - ping-pong NxN coefficient reorder buffer (transpose / zigzag / raster)
module block_reorder #(
    parameter int QW    = 15,
    parameter int N     = 8,
    parameter int LANES = 2
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic [N*QW-1:0]                    d,
    input  logic [$clog2(N)-1:0]               d_cnt,
    input  logic [1:0]                         d_mode,
    input  logic                               d_valid,
    output logic                               d_hold,
    output logic [LANES*QW-1:0]                q,
    output logic [$clog2(N*N/LANES)-1:0]       q_cnt,
    output logic [1:0]                         q_mode,
    output logic                               q_valid,
    input  logic                               q_hold
);
    localparam int LN    = $clog2(N);
    localparam int AW    = $clog2(N*N);
    localparam int BW    = $clog2(N*N/LANES);
    localparam int BEATS = N*N/LANES;

    // Zigzag scan built by walking anti-diagonals; entry k holds the raster index.
    function automatic logic [N*N*AW-1:0] zz_table();
        logic [N*N*AW-1:0] t;
        int k;
        int r;
        t = '0;
        k = 0;
        for (int s = 0; s < 2*N-1; s++) begin
            for (int i = 0; i < N; i++) begin
                r = (s % 2 == 0) ? ((s < N ? s : N-1) - i) : ((s < N ? 0 : s-N+1) + i);
                if (r >= 0 && r < N && s-r >= 0 && s-r < N) begin
                    t[k*AW +: AW] = AW'(r*N + s - r);
                    k++;
                end
            end
        end
        return t;
    endfunction

    localparam logic [N*N*AW-1:0] ZZ_TBL = zz_table();

    logic [QW-1:0]  mem [2][N*N];
    logic [1:0]     full;
    logic [1:0]     mode_r [2];
    logic           wr_bank;
    logic           rd_bank;
    logic [LN-1:0]  wr_row;
    logic [BW-1:0]  rd_beat;
    logic           wr_fire;
    logic           rd_fire;

    assign d_hold  = full[wr_bank];
    assign q_valid = full[rd_bank];
    assign q_mode  = mode_r[rd_bank];
    assign q_cnt   = rd_beat;
    assign wr_fire = d_valid && !d_hold;
    assign rd_fire = q_valid && !q_hold;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            full      <= 2'b00;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_row    <= '0;
            rd_beat   <= '0;
            mode_r[0] <= 2'd0;
            mode_r[1] <= 2'd0;
        end else begin
            if (wr_fire) begin
                if (wr_row == '0)
                    mode_r[wr_bank] <= d_mode;
                if (wr_row == LN'(N-1)) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                    wr_row        <= '0;
                end else begin
                    wr_row <= wr_row + 1'b1;
                end
            end
            // A write only targets an empty bank and a read only a full one, so they never collide.
            if (rd_fire) begin
                if (rd_beat == BW'(BEATS-1)) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= ~rd_bank;
                    rd_beat       <= '0;
                end else begin
                    rd_beat <= rd_beat + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int c = 0; c < N; c++)
                mem[wr_bank][{wr_row, LN'(c)}] <= d[c*QW +: QW];
        end
    end

    always_comb begin
        logic [AW-1:0] k;
        logic [AW-1:0] addr;
        q    = '0;
        k    = '0;
        addr = '0;
        for (int l = 0; l < LANES; l++) begin
            k = AW'(int'(rd_beat) * LANES + l);
            case (q_mode)
                2'd0:    addr = {k[LN-1:0], k[AW-1:LN]};
                2'd1:    addr = (N == 8) ? ZZ_TBL[int'(k)*AW +: AW] : k;
                default: addr = k;
            endcase
            q[l*QW +: QW] = mem[rd_bank][addr];
        end
    end

    always @(posedge clk) begin
        if (resetn && wr_fire)
            assert (d_cnt == wr_row);
        if (resetn && q_valid)
            assert (q_mode != 2'd3 && (q_mode != 2'd1 || N == 8));
    end
endmodule

// File: tb/tb_block_reorder.sv
// tb/tb_block_reorder.sv - scoreboard bench for block_reorder (8x8/2 lanes and 4x4/1 lane)
module tb_block_reorder;
    localparam int QW    = 15;
    localparam int N     = 8;
    localparam int LANES = 2;
    localparam int BEATS = N*N/LANES;

    typedef struct {
        logic [LANES*QW-1:0] q;
        logic [4:0]          cnt;
        logic [1:0]          mode;
    } beat_t;

    typedef struct {
        logic [QW-1:0] q;
        logic [3:0]    cnt;
    } beat4_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                resetn;
    logic [N*QW-1:0]     d;
    logic [2:0]          d_cnt;
    logic [1:0]          d_mode;
    logic                d_valid;
    logic                d_hold;
    logic [LANES*QW-1:0] q;
    logic [4:0]          q_cnt;
    logic [1:0]          q_mode;
    logic                q_valid;
    logic                q_hold;

    logic [4*QW-1:0]     d4;
    logic [1:0]          d4_cnt;
    logic                d4_valid;
    logic                d4_hold;
    logic [QW-1:0]       q4;
    logic [3:0]          q4_cnt;
    logic [1:0]          q4_mode;
    logic                q4_valid;
    logic                q4_hold;

    block_reorder #(.QW(QW), .N(N), .LANES(LANES)) dut (
        .clk(clk), .resetn(resetn), .d(d), .d_cnt(d_cnt), .d_mode(d_mode), .d_valid(d_valid),
        .d_hold(d_hold), .q(q), .q_cnt(q_cnt), .q_mode(q_mode), .q_valid(q_valid), .q_hold(q_hold)
    );

    block_reorder #(.QW(QW), .N(4), .LANES(1)) dut4 (
        .clk(clk), .resetn(resetn), .d(d4), .d_cnt(d4_cnt), .d_mode(2'd0), .d_valid(d4_valid),
        .d_hold(d4_hold), .q(q4), .q_cnt(q4_cnt), .q_mode(q4_mode), .q_valid(q4_valid), .q_hold(q4_hold)
    );

    int checks = 0;
    int errors = 0;
    int hold_mode = 0;
    int blk [N][N];
    beat_t  exp_q [$];
    beat4_t exp4_q [$];

    int zz [64] = '{ 0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
                    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
                    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
                    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Reference: coefficient k of the output stream taken straight from the stored block.
    task automatic push_block(input int mode);
        beat_t e;
        int k;
        int v;
        int r;
        for (int b = 0; b < BEATS; b++) begin
            e.q = '0;
            for (int l = 0; l < LANES; l++) begin
                k = b*LANES + l;
                case (mode)
                    0:       v = blk[k % N][k / N];
                    1:       begin r = zz[k]; v = blk[r / N][r % N]; end
                    default: v = blk[k / N][k % N];
                endcase
                e.q[l*QW +: QW] = QW'(v);
            end
            e.cnt  = 5'(b);
            e.mode = 2'(mode);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_row(input int r, output int stall);
        for (int c = 0; c < N; c++)
            d[c*QW +: QW] = QW'(blk[r][c]);
        d_cnt   = 3'(r);
        d_valid = 1'b1;
        stall   = 0;
        forever begin
            @(negedge clk);
            if (!d_hold) break;
            stall++;
            if (stall > 3000) begin
                chk("row_accept_timeout", stall, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        d_valid = 1'b0;
    endtask

    task automatic send_block(input int mode, input bit pattern, input int nrows, input bit gaps,
                              input bit chk_lat, output int stall0);
        int st;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                blk[r][c] = pattern ? N*r + c
                                    : int'($urandom_range(0, (1 << QW) - 1)) - (1 << (QW - 1));
        stall0 = 0;
        for (int r = 0; r < nrows; r++) begin
            if (gaps)
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            if (chk_lat && r == N-1)
                chk("q_valid_before_last_row", int'(q_valid), 0);
            d_mode = 2'(mode);
            send_row(r, st);
            if (r == 0) stall0 = st;
        end
        if (nrows == N) begin
            push_block(mode);
            if (chk_lat) chk("q_valid_after_last_row", int'(q_valid), 1);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0 && !q_valid && exp4_q.size() == 0 && !q4_valid) break;
            n++;
            if (n > 5000) begin
                chk("drain_timeout", exp_q.size() + exp4_q.size(), 0);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        case (hold_mode)
            0:       q_hold = 1'b0;
            1:       q_hold = 1'($urandom_range(0, 1));
            default: q_hold = 1'b1;
        endcase
    end

    // Compare whatever is presented against the head of the queue; pop only on transfer.
    always @(negedge clk) begin
        if (resetn === 1'b1 && q_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got q=%h q_cnt=%0d, want no beat", q, q_cnt);
            end else begin
                if (q !== exp_q[0].q || q_cnt !== exp_q[0].cnt || q_mode !== exp_q[0].mode) begin
                    errors++;
                    $display("FAIL beat: got q=%h q_cnt=%0d q_mode=%0d, want q=%h q_cnt=%0d q_mode=%0d",
                             q, q_cnt, q_mode, exp_q[0].q, exp_q[0].cnt, exp_q[0].mode);
                end
                if (!q_hold) void'(exp_q.pop_front());
            end
        end
        if (resetn === 1'b1 && q4_valid === 1'b1) begin
            checks++;
            if (exp4_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat4: got q=%0d q_cnt=%0d, want no beat", q4, q4_cnt);
            end else begin
                if (q4 !== exp4_q[0].q || q4_cnt !== exp4_q[0].cnt) begin
                    errors++;
                    $display("FAIL beat4: got q=%0d q_cnt=%0d, want q=%0d q_cnt=%0d",
                             q4, q4_cnt, exp4_q[0].q, exp4_q[0].cnt);
                end
                if (!q4_hold) void'(exp4_q.pop_front());
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        int st;
        beat4_t e4;
        resetn   = 1'b0;
        d        = '0;
        d_cnt    = '0;
        d_mode   = '0;
        d_valid  = 1'b0;
        q_hold   = 1'b0;
        d4       = '0;
        d4_cnt   = '0;
        d4_valid = 1'b0;
        q4_hold  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        chk("reset_d_hold", int'(d_hold), 0);
        chk("reset_q_valid", int'(q_valid), 0);
        chk("reset_q_cnt", int'(q_cnt), 0);
        chk("reset_q_mode", int'(q_mode), 0);
        chk("reset_q4_valid", int'(q4_valid), 0);

        send_block(0, 1'b1, N, 1'b0, 1'b1, st);
        wait_drain();
        send_block(1, 1'b1, N, 1'b0, 1'b0, st);
        wait_drain();

        send_block(0, 1'b1, N, 1'b0, 1'b0, st);
        send_block(1, 1'b0, N, 1'b0, 1'b0, st);
        send_block(2, 1'b0, N, 1'b0, 1'b0, st);
        chk("block2_stalled", int'(st > 0), 1);
        wait_drain();

        hold_mode = 1;
        for (int b = 0; b < 20; b++)
            send_block(int'($urandom_range(0, 2)), 1'b0, N, 1'b1, 1'b0, st);
        wait_drain();
        hold_mode = 0;
        @(posedge clk);
        #1;

        send_block(0, 1'b1, N, 1'b0, 1'b0, st);
        repeat (14) begin @(posedge clk); #1; end
        hold_mode = 2;
        send_block(2, 1'b0, 4, 1'b0, 1'b0, st);
        resetn = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        hold_mode = 0;
        chk("midreset_q_valid", int'(q_valid), 0);
        chk("midreset_d_hold", int'(d_hold), 0);
        chk("midreset_q_cnt", int'(q_cnt), 0);
        send_block(1, 1'b0, N, 1'b0, 1'b0, st);
        wait_drain();

        for (int r = 0; r < 4; r++) begin
            int n;
            for (int c = 0; c < 4; c++)
                d4[c*QW +: QW] = QW'(4*r + c);
            d4_cnt   = 2'(r);
            d4_valid = 1'b1;
            n = 0;
            forever begin
                @(negedge clk);
                if (!d4_hold) break;
                n++;
                if (n > 100) begin
                    chk("row4_accept_timeout", n, 0);
                    break;
                end
            end
            @(posedge clk);
            #1;
            d4_valid = 1'b0;
        end
        for (int k = 0; k < 16; k++) begin
            e4.q   = QW'((k % 4) * 4 + k / 4);
            e4.cnt = 4'(k);
            exp4_q.push_back(e4);
        end
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
